// File: rtl/message_rx_buffer_pkg.sv
// Shared definitions for the message counter / receive buffer pair.
package message_rx_buffer_pkg;

  // Message layout shared with the counter: region select bits followed by count bits.
  localparam int MSG_WIDTH    = 64;
  localparam int REGION_WIDTH = 16;

  // Receive-side control states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_FLUSH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/message_rx_buffer_sync_fifo_fwft.sv
// First-word fall-through FIFO: head entry is visible on o_data while non-empty.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module sync_fifo_fwft
  import message_rx_buffer_pkg::*;
#(
  parameter int WIDTH = MSG_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic                     o_push_ok,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [$clog2(DEPTH):0]   o_level_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [LW-1:0]    w_level_next;
  logic             w_empty;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LW'(DEPTH));
  // A flush wins over both ports; a full FIFO only takes a write if a slot frees this cycle.
  assign w_do_pop  = i_pop && !i_clear && !w_empty;
  assign w_do_push = i_push && !i_clear && (!w_full || w_do_pop);

  // Post-edge occupancy, used by the parent for its registered backpressure.
  always_comb begin
    w_level_next = r_level;
    if (i_clear)
      w_level_next = '0;
    else if (w_do_push && !w_do_pop)
      w_level_next = r_level + LW'(1);
    else if (!w_do_push && w_do_pop)
      w_level_next = r_level - LW'(1);
  end

  // Storage write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_next;
    end
  end

  // Stale storage after a flush is masked so the head reads 0 whenever empty.
  assign o_data       = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_empty      = w_empty;
  assign o_level      = r_level;
  assign o_level_next = w_level_next;
  assign o_push_ok    = w_do_push;

endmodule

// File: rtl/message_rx_buffer.sv
// Consumer end of the message-counter stream: buffers counter messages, throttles the
// counter through pause, restarts it on a flush and flags when the region has drained.
module message_rx_buffer
  import message_rx_buffer_pkg::*;
#(
  parameter int WIDTH = MSG_WIDTH,
  parameter int DEPTH = 8,
  parameter int SKID  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         msg_in,
  input  logic                     msg_valid,
  input  logic                     msg_done,
  output logic                     pause,
  output logic                     reset_counter,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     all_done,
  output logic                     overflow,
  output logic [31:0]              msg_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int LW = $clog2(DEPTH) + 1;

  rx_state_t     r_state;
  rx_state_t     w_state_next;
  logic          r_pause;
  logic          r_overflow;
  logic [31:0]   r_msg_count;

  logic          w_push_req;
  logic          w_push_ok;
  logic          w_pop;
  logic          w_fifo_empty;
  logic [LW-1:0] w_level;
  logic [LW-1:0] w_level_next;
  logic          w_pause_next;

  // Messages are only taken while a region is being collected or drained.
  assign w_push_req = msg_valid &&
                      ((r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_DRAIN));
  assign w_pop      = !w_fifo_empty && out_ready;

  sync_fifo_fwft #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (clear),
    .i_push       (w_push_req),
    .i_data       (msg_in),
    .i_pop        (w_pop),
    .o_push_ok    (w_push_ok),
    .o_data       (out_data),
    .o_empty      (w_fifo_empty),
    .o_level      (w_level),
    .o_level_next (w_level_next)
  );

  // Next-state decode; clear overrides everything. "Empty" means nothing held and nothing
  // arriving this cycle, so DONE is never entered with a message still in flight.
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = ST_FLUSH;
    end else begin
      case (r_state)
        ST_IDLE:  if (msg_valid) w_state_next = ST_RUN;
        ST_RUN:   if (msg_done)
                    w_state_next = (w_fifo_empty && !w_push_ok) ? ST_DONE : ST_DRAIN;
        ST_DRAIN: if (w_fifo_empty && !w_push_ok) w_state_next = ST_DONE;
        ST_DONE:  w_state_next = ST_DONE;
        ST_FLUSH: w_state_next = ST_IDLE;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  // Backpressure reserves SKID free slots for the counter's one-cycle reaction time.
  assign w_pause_next = ((w_state_next == ST_RUN) || (w_state_next == ST_DRAIN)) &&
                        (w_level_next >= LW'(DEPTH - SKID));

  // State register with registered pause, sticky overflow and accepted-message count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pause     <= 1'b0;
      r_overflow  <= 1'b0;
      r_msg_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_pause <= w_pause_next;
      if (clear) begin
        r_overflow  <= 1'b0;
        r_msg_count <= '0;
      end else begin
        if (w_push_req && !w_push_ok) r_overflow  <= 1'b1;
        if (w_push_ok)                r_msg_count <= r_msg_count + 32'd1;
      end
    end
  end

  assign pause         = r_pause;
  assign reset_counter = (r_state == ST_FLUSH);
  assign all_done      = (r_state == ST_DONE);
  assign overflow      = r_overflow;
  assign msg_count     = r_msg_count;
  assign out_valid     = !w_fifo_empty;
  assign level         = w_level;

endmodule
